dual_port_bank_arbiter: RTL and testbench
=========================================

// Module: dual_port_bank_arbiter
// PURPOSE
//  Shares one dual-port multi-bank memory between NUM_REQ requesters.
//  Each cycle it grants up to two requests: one on port A, one on port B.
//  It never issues two accesses to the same bank in one cycle.
//  Read data is routed back to the requester that issued the read.
//  Both memory clocks (i_clk_a, i_clk_b) are tied to i_clk at the top level.
// PARAMETERS
//  WIDTH       8  data word width
//  ADDR_TOTAL  5  word address width; bank = addr[ADDR_TOTAL-1 -: BANK_BITS]
//  NUM_BANK    4  number of banks; power of 2, >=2; BANK_BITS = $clog2(NUM_BANK)
//  NUM_REQ     4  number of requesters, >=2
//  MEM_LAT     1  memory read latency, in cycles from command sample to dout valid
// PORTS
//  i_clk         in   1                single clock; everything on posedge
//  i_rst         in   1                synchronous reset, active-high
//  i_req_valid   in   NUM_REQ          per-requester request valid
//  o_req_ready   out  NUM_REQ          per-requester grant; handshake = valid & ready
//  i_req_we      in   NUM_REQ          1 = write, 0 = read
//  i_req_addr    in   NUM_REQ*ADDR_TOTAL  packed; requester r uses slice r
//  i_req_din     in   NUM_REQ*WIDTH    packed write data
//  o_rsp_valid   out  NUM_REQ          1-cycle pulse: read data ready for requester r
//  o_rsp_data    out  NUM_REQ*WIDTH    packed read data; holds last value
//  o_mem_en_a / o_mem_en_b      out  1           port enables
//  o_mem_we_a / o_mem_we_b      out  1           port write enables
//  o_mem_addr_a / o_mem_addr_b  out  ADDR_TOTAL  port addresses
//  o_mem_din_a / o_mem_din_b    out  WIDTH       port write data
//  i_mem_dout_a / i_mem_dout_b  in   WIDTH       port read data
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 while i_rst=1 and in the first cycle after it.
//   - Round-robin pointer ptr = 0; response pipeline is cleared.
//  Request rules:
//   - A requester holds valid, we, addr and din stable until ready is seen.
//   - o_req_ready is combinational from ptr and the current valids.
//   - ready may assert in the same cycle that valid rises; it never asserts without valid.
//  Arbitration, evaluated every cycle:
//   - Port A: the first valid requester found scanning ptr, ptr+1, ... (mod NUM_REQ).
//   - Port B: the next valid requester after A in scan order whose bank differs from A's bank.
//   - If no requester qualifies for B, port B stays idle.
//   - No requester is granted twice in one cycle.
//   - Bank conflicts wait; they are never dropped.
//  Pointer update:
//   - ptr <= (index of the last requester granted this cycle + 1) mod NUM_REQ.
//   - ptr is unchanged when nothing is granted.
//   - Any continuously-valid requester is granted within NUM_REQ cycles.
//  Command stage:
//   - A handshake at edge E0 registers o_mem_* for the cycle after E0.
//   - An idle port has en=0 and we=0 in that cycle; addr and din are don't-care.
//  Response path:
//   - A shift register of depth MEM_LAT+1 carries {valid, requester id, port} for reads.
//   - Writes produce no response.
//   - The read data is sampled one cycle after dout is valid.
//   - o_rsp_valid[id] pulses high for the cycle after edge E0+MEM_LAT+1 (2 cycles after handshake at MEM_LAT=1).
//   - o_rsp_data[id] is updated at that edge and holds it.
//   - Two responses in the same cycle always go to different requesters.
//   - Throughput is 2 accesses/cycle when banks differ.
//  Ordering:
//   - Per requester, responses return in issue order; latency is fixed.
//   - Write then read to the same address, handshaken in later cycles, returns the new data.
//  Reset mid-operation:
//   - In-flight commands and responses are discarded.
//   - No o_rsp_valid is issued for reads handshaken before reset.
// TESTING
//  Reset:
//   i_rst=1 for 2 cycles with all valid=1 -> ready=0, mem_en_a/b=0, rsp_valid=0, ptr=0.
//  Dual issue:
//   r0 wr addr5=0x12 and r1 wr addr13=0x34 in the same cycle -> both ready.
//   -> next cycle en_a/we_a addr5 din 0x12; en_b/we_b addr13 din 0x34.
//  Bank conflict:
//   r0 rd addr5 and r2 rd addr2 (both bank0) -> r0 ready cycle N, r2 ready cycle N+1.
//   -> rsp_data[0]=0x12.
//  Latency:
//   r3 rd addr13 handshaken at edge E -> rsp_valid[3] only in the cycle after E+2, data 0x34.
//  Fairness:
//   All valid, addrs 0/8/16/24 (distinct banks) -> grant pairs {0,1},{2,3},{0,1}, ...
//   All valid, addrs 0/1/2/3 (same bank) -> grants 0,1,2,3,0 on port A only.
//  Mid-flight reset:
//   i_rst=1 the cycle after a read handshake -> no rsp_valid; next request is granted normally.

Source files
------------

// File: rtl/dual_port_bank_arbiter.sv
// dual_port_bank_arbiter
//
// Shares one dual-port, multi-bank memory between NUM_REQ requesters.
// Each cycle up to two requests are granted: one on port A and one on
// port B. The two granted requests always target different banks. Read
// data is routed back to the requester that issued the read. The memory
// port clocks are tied to i_clk outside this module.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/ready   per-requester handshake (ready is combinational)
//   i_req_we/addr/din   per-requester command, packed by requester index
//   o_rsp_valid/data    per-requester read response (pulse / held data)
//   o_mem_*_a, _b       registered memory commands for ports A and B
//   i_mem_dout_a, _b    memory read data, valid MEM_LAT cycles after sample
module dual_port_bank_arbiter #(
   parameter int WIDTH      = 8,
   parameter int ADDR_TOTAL = 5,
   parameter int NUM_BANK   = 4,
   parameter int NUM_REQ    = 4,
   parameter int MEM_LAT    = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic [NUM_REQ-1:0]            i_req_we,
   input  logic [NUM_REQ*ADDR_TOTAL-1:0] i_req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]      i_req_din,
   output logic [NUM_REQ-1:0]            o_rsp_valid,
   output logic [NUM_REQ*WIDTH-1:0]      o_rsp_data,
   output logic                          o_mem_en_a,
   output logic                          o_mem_en_b,
   output logic                          o_mem_we_a,
   output logic                          o_mem_we_b,
   output logic [ADDR_TOTAL-1:0]         o_mem_addr_a,
   output logic [ADDR_TOTAL-1:0]         o_mem_addr_b,
   output logic [WIDTH-1:0]              o_mem_din_a,
   output logic [WIDTH-1:0]              o_mem_din_b,
   input  logic [WIDTH-1:0]              i_mem_dout_a,
   input  logic [WIDTH-1:0]              i_mem_dout_b
);

   localparam int BANK_BITS = $clog2(NUM_BANK);
   localparam int ID_BITS   = $clog2(NUM_REQ);

   // Tag carried alongside an in-flight read: which requester gets the data.
   typedef struct packed {
      logic               valid;
      logic [ID_BITS-1:0] id;
   } rsp_tag_t;

   // ------------------------------------------------------------------
   // Unpack per-requester fields
   // ------------------------------------------------------------------
   logic [ADDR_TOTAL-1:0] addr_arr [NUM_REQ];
   logic [WIDTH-1:0]      din_arr  [NUM_REQ];
   logic [BANK_BITS-1:0]  bank_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = i_req_addr[gi*ADDR_TOTAL +: ADDR_TOTAL];
         assign din_arr[gi]  = i_req_din[gi*WIDTH +: WIDTH];
         // Bank select is the top BANK_BITS of the word address.
         assign bank_arr[gi] = i_req_addr[gi*ADDR_TOTAL + ADDR_TOTAL - 1 -: BANK_BITS];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic [ID_BITS-1:0]   ptr_reg;
   logic [ID_BITS-1:0]   ptr_next;
   logic                 rst_hold_reg;
   logic [NUM_REQ-1:0]   valid_eff;
   logic                 found_a;
   logic                 found_b;
   logic [ID_BITS-1:0]   id_a;
   logic [ID_BITS-1:0]   id_b;
   logic [BANK_BITS-1:0] bank_a;
   logic [ID_BITS-1:0]   cand;
   logic [NUM_REQ-1:0]   grant;

   function automatic logic [ID_BITS-1:0] next_id(input logic [ID_BITS-1:0] id);
      return ID_BITS'((int'(id) + 1) % NUM_REQ);
   endfunction

   // No grants while in reset nor in the first cycle after it, so every
   // output is quiet for that cycle.
   assign valid_eff = (i_rst || rst_hold_reg) ? '0 : i_req_valid;

   // Single scan in round-robin order: the first valid requester takes
   // port A; the next one whose bank differs from A's takes port B.
   always_comb begin
      found_a = 1'b0;
      found_b = 1'b0;
      id_a    = '0;
      id_b    = '0;
      bank_a  = '0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_BITS'((int'(ptr_reg) + i) % NUM_REQ);
         if (valid_eff[cand]) begin
            if (!found_a) begin
               found_a = 1'b1;
               id_a    = cand;
               bank_a  = bank_arr[cand];
            end else if (!found_b && (bank_arr[cand] != bank_a)) begin
               found_b = 1'b1;
               id_b    = cand;
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (found_a) grant[id_a] = 1'b1;
      if (found_b) grant[id_b] = 1'b1;
   end

   assign o_req_ready = grant;

   // B always lies after A in scan order, so it is the last one granted.
   always_comb begin
      ptr_next = ptr_reg;
      if (found_b)      ptr_next = next_id(id_b);
      else if (found_a) ptr_next = next_id(id_a);
   end

   // ------------------------------------------------------------------
   // Command stage
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rst_hold_reg <= 1'b1;
         ptr_reg      <= '0;
         o_mem_en_a   <= 1'b0;
         o_mem_we_a   <= 1'b0;
         o_mem_addr_a <= '0;
         o_mem_din_a  <= '0;
         o_mem_en_b   <= 1'b0;
         o_mem_we_b   <= 1'b0;
         o_mem_addr_b <= '0;
         o_mem_din_b  <= '0;
      end else begin
         rst_hold_reg <= 1'b0;
         ptr_reg      <= ptr_next;
         o_mem_en_a   <= found_a;
         o_mem_we_a   <= found_a & i_req_we[id_a];
         o_mem_addr_a <= found_a ? addr_arr[id_a] : '0;
         o_mem_din_a  <= found_a ? din_arr[id_a]  : '0;
         o_mem_en_b   <= found_b;
         o_mem_we_b   <= found_b & i_req_we[id_b];
         o_mem_addr_b <= found_b ? addr_arr[id_b] : '0;
         o_mem_din_b  <= found_b ? din_arr[id_b]  : '0;
      end
   end

   // ------------------------------------------------------------------
   // Response path
   // ------------------------------------------------------------------
   // Stage k holds the tag of a read handshaken k+1 edges ago; the last
   // stage lines up with dout being valid, so its data is captured then.
   rsp_tag_t tag_a_reg [MEM_LAT+1];
   rsp_tag_t tag_b_reg [MEM_LAT+1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k <= MEM_LAT; k++) begin
            tag_a_reg[k] <= '0;
            tag_b_reg[k] <= '0;
         end
      end else begin
         tag_a_reg[0] <= {found_a & ~i_req_we[id_a], id_a};
         tag_b_reg[0] <= {found_b & ~i_req_we[id_b], id_b};
         for (int k = 1; k <= MEM_LAT; k++) begin
            tag_a_reg[k] <= tag_a_reg[k-1];
            tag_b_reg[k] <= tag_b_reg[k-1];
         end
      end
   end

   logic [NUM_REQ-1:0]       rsp_valid_next;
   logic [NUM_REQ*WIDTH-1:0] rsp_data_next;

   // A and B were granted to different requesters, so the two writes
   // below never land on the same slice.
   always_comb begin
      rsp_valid_next = '0;
      rsp_data_next  = o_rsp_data;
      if (tag_a_reg[MEM_LAT].valid) begin
         rsp_valid_next[tag_a_reg[MEM_LAT].id] = 1'b1;
         rsp_data_next[int'(tag_a_reg[MEM_LAT].id)*WIDTH +: WIDTH] = i_mem_dout_a;
      end
      if (tag_b_reg[MEM_LAT].valid) begin
         rsp_valid_next[tag_b_reg[MEM_LAT].id] = 1'b1;
         rsp_data_next[int'(tag_b_reg[MEM_LAT].id)*WIDTH +: WIDTH] = i_mem_dout_b;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_valid <= '0;
         o_rsp_data  <= '0;
      end else begin
         o_rsp_valid <= rsp_valid_next;
         o_rsp_data  <= rsp_data_next;
      end
   end

endmodule

// File: tb/tb_dual_port_bank_arbiter.sv
module tb_dual_port_bank_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [3:0]  req_we;
   logic [19:0] req_addr;
   logic [31:0] req_din;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        mem_en_a, mem_en_b, mem_we_a, mem_we_b;
   logic [4:0]  mem_addr_a, mem_addr_b;
   logic [7:0]  mem_din_a, mem_din_b;
   logic [7:0]  dout_a, dout_b;

   dual_port_bank_arbiter #(
      .WIDTH(8), .ADDR_TOTAL(5), .NUM_BANK(4), .NUM_REQ(4), .MEM_LAT(1)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_req_valid(req_valid),
      .o_req_ready(req_ready),
      .i_req_we(req_we),
      .i_req_addr(req_addr),
      .i_req_din(req_din),
      .o_rsp_valid(rsp_valid),
      .o_rsp_data(rsp_data),
      .o_mem_en_a(mem_en_a),
      .o_mem_en_b(mem_en_b),
      .o_mem_we_a(mem_we_a),
      .o_mem_we_b(mem_we_b),
      .o_mem_addr_a(mem_addr_a),
      .o_mem_addr_b(mem_addr_b),
      .o_mem_din_a(mem_din_a),
      .o_mem_din_b(mem_din_b),
      .i_mem_dout_a(dout_a),
      .i_mem_dout_b(dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port memory model, one-cycle registered read.
   logic [7:0] mem [32];
   logic       mem_clear;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
         dout_a <= 8'h00;
         dout_b <= 8'h00;
      end else begin
         if (mem_en_a) begin
            if (mem_we_a) mem[mem_addr_a] <= mem_din_a;
            else          dout_a <= mem[mem_addr_a];
         end
         if (mem_en_b) begin
            if (mem_we_b) mem[mem_addr_b] <= mem_din_b;
            else          dout_b <= mem[mem_addr_b];
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [19:0] addr;     // {r3, r2, r1, r0}
      logic [3:0]  ready;
      logic        en_a;
      logic [4:0]  addr_a;
      logic        en_b;
      logic [4:0]  addr_b;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] v, input logic [4:0] a3, input logic [4:0] a2,
                      input logic [4:0] a1, input logic [4:0] a0, input logic [3:0] rdy,
                      input logic ea, input logic [4:0] aa, input logic eb, input logic [4:0] ab);
      vec_t t;
      t.valid  = v;
      t.addr   = {a3, a2, a1, a0};
      t.ready  = rdy;
      t.en_a   = ea;
      t.addr_a = aa;
      t.en_b   = eb;
      t.addr_b = ab;
      vq.push_back(t);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      req_valid = 4'b0000;
      req_we    = 4'b0000;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_clear = 1'b1;
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_we    = 4'b0000;
      req_addr  = {5'd24, 5'd16, 5'd8, 5'd0};
      req_din   = 32'h0;

      // Distinct banks, all reading: pairs {0,1},{2,3},...
      add(4'b1111, 5'd24, 5'd16, 5'd8, 5'd0, 4'b0000, 1'b0, 5'd0,  1'b0, 5'd0);   // first cycle after reset
      add(4'b1111, 5'd24, 5'd16, 5'd8, 5'd0, 4'b0011, 1'b1, 5'd0,  1'b1, 5'd8);
      add(4'b1111, 5'd24, 5'd16, 5'd8, 5'd0, 4'b1100, 1'b1, 5'd16, 1'b1, 5'd24);
      add(4'b1111, 5'd24, 5'd16, 5'd8, 5'd0, 4'b0011, 1'b1, 5'd0,  1'b1, 5'd8);
      add(4'b1100, 5'd24, 5'd16, 5'd8, 5'd0, 4'b1100, 1'b1, 5'd16, 1'b1, 5'd24);
      add(4'b0000, 5'd0,  5'd0,  5'd0, 5'd0, 4'b0000, 1'b0, 5'd0,  1'b0, 5'd0);
      // Same bank: one grant per cycle on port A, rotating 0,1,2,3,0
      add(4'b1111, 5'd3, 5'd2, 5'd1, 5'd0, 4'b0001, 1'b1, 5'd0, 1'b0, 5'd0);
      add(4'b1111, 5'd3, 5'd2, 5'd1, 5'd0, 4'b0010, 1'b1, 5'd1, 1'b0, 5'd0);
      add(4'b1111, 5'd3, 5'd2, 5'd1, 5'd0, 4'b0100, 1'b1, 5'd2, 1'b0, 5'd0);
      add(4'b1111, 5'd3, 5'd2, 5'd1, 5'd0, 4'b1000, 1'b1, 5'd3, 1'b0, 5'd0);
      add(4'b1111, 5'd3, 5'd2, 5'd1, 5'd0, 4'b0001, 1'b1, 5'd0, 1'b0, 5'd0);
      add(4'b1110, 5'd3, 5'd2, 5'd1, 5'd0, 4'b0010, 1'b1, 5'd1, 1'b0, 5'd0);
      add(4'b1100, 5'd3, 5'd2, 5'd1, 5'd0, 4'b0100, 1'b1, 5'd2, 1'b0, 5'd0);
      add(4'b1000, 5'd3, 5'd2, 5'd1, 5'd0, 4'b1000, 1'b1, 5'd3, 1'b0, 5'd0);
      add(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd0, 1'b0, 5'd0);
      // Mixed banks, B search skipping and wrapping
      add(4'b1010, 5'd2,  5'd0,  5'd9,  5'd0, 4'b1010, 1'b1, 5'd9,  1'b1, 5'd2);
      add(4'b1001, 5'd30, 5'd0,  5'd0,  5'd4, 4'b1001, 1'b1, 5'd4,  1'b1, 5'd30);
      add(4'b0111, 5'd0,  5'd12, 5'd10, 5'd8, 4'b0001, 1'b1, 5'd8,  1'b0, 5'd0);
      add(4'b0110, 5'd0,  5'd12, 5'd10, 5'd8, 4'b0010, 1'b1, 5'd10, 1'b0, 5'd0);
      add(4'b0100, 5'd0,  5'd12, 5'd10, 5'd8, 4'b0100, 1'b1, 5'd12, 1'b0, 5'd0);
      add(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0, 4'b0000, 1'b0, 5'd0,  1'b0, 5'd0);
      add(4'b1111, 5'd18, 5'd17, 5'd1,  5'd0, 4'b1001, 1'b1, 5'd18, 1'b1, 5'd0);
      add(4'b0110, 5'd18, 5'd17, 5'd1,  5'd0, 4'b0110, 1'b1, 5'd1,  1'b1, 5'd17);
      add(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0, 4'b0000, 1'b0, 5'd0,  1'b0, 5'd0);

      // ---------------- reset with all requesters valid ----------------
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         mem_clear = 1'b0;
         check($sformatf("reset%0d ready", c), 32'(req_ready), 32'h0);
         check($sformatf("reset%0d en_a", c), 32'(mem_en_a), 32'h0);
         check($sformatf("reset%0d en_b", c), 32'(mem_en_b), 32'h0);
         check($sformatf("reset%0d rsp_valid", c), 32'(rsp_valid), 32'h0);
         check($sformatf("reset%0d rsp_data", c), rsp_data, 32'h0);
         $display("reset cycle %0d: ready=%b en_a=%b en_b=%b rsp_valid=%b",
                  c, req_ready, mem_en_a, mem_en_b, rsp_valid);
      end

      // ---------------- table-driven arbitration ----------------
      for (int v = 0; v < vq.size(); v++) begin
         @(negedge clk);
         rst       = 1'b0;
         req_valid = vq[v].valid;
         req_we    = 4'b0000;
         req_addr  = vq[v].addr;
         #1;
         check($sformatf("vec%0d ready", v), 32'(req_ready), 32'(vq[v].ready));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d en_a", v), 32'(mem_en_a), 32'(vq[v].en_a));
         check($sformatf("vec%0d en_b", v), 32'(mem_en_b), 32'(vq[v].en_b));
         check($sformatf("vec%0d we", v), 32'({mem_we_b, mem_we_a}), 32'h0);
         if (vq[v].en_a) check($sformatf("vec%0d addr_a", v), 32'(mem_addr_a), 32'(vq[v].addr_a));
         if (vq[v].en_b) check($sformatf("vec%0d addr_b", v), 32'(mem_addr_b), 32'(vq[v].addr_b));
         $display("vec %0d: valid=%b ready=%b en_a=%b addr_a=%0d en_b=%b addr_b=%0d",
                  v, vq[v].valid, req_ready, mem_en_a, mem_addr_a, mem_en_b, mem_addr_b);
      end

      for (int c = 0; c < 3; c++) idle_cycle();

      // ---------------- dual issue: r0 wr 5=0x12, r1 wr 13=0x34 ----------------
      @(negedge clk);
      req_valid = 4'b0011;
      req_we    = 4'b0011;
      req_addr  = {5'd0, 5'd0, 5'd13, 5'd5};
      req_din   = {8'h00, 8'h00, 8'h34, 8'h12};
      #1;
      check("dual ready", 32'(req_ready), 32'h3);
      @(posedge clk);
      #1;
      check("dual a cmd", 32'({mem_en_a, mem_we_a, mem_addr_a, mem_din_a}), 32'({1'b1, 1'b1, 5'd5, 8'h12}));
      check("dual b cmd", 32'({mem_en_b, mem_we_b, mem_addr_b, mem_din_b}), 32'({1'b1, 1'b1, 5'd13, 8'h34}));
      $display("dual issue: a en=%b we=%b addr=%0d din=%h  b en=%b we=%b addr=%0d din=%h",
               mem_en_a, mem_we_a, mem_addr_a, mem_din_a, mem_en_b, mem_we_b, mem_addr_b, mem_din_b);
      for (int c = 0; c < 3; c++) begin
         idle_cycle();
         check($sformatf("write no rsp %0d", c), 32'(rsp_valid), 32'h0);
      end

      // ---------------- latency: r3 rd 13 ----------------
      @(negedge clk);
      req_valid = 4'b1000;
      req_we    = 4'b0000;
      req_addr  = {5'd13, 5'd0, 5'd0, 5'd0};
      #1;
      check("lat ready", 32'(req_ready), 32'h8);
      @(posedge clk);   // handshake edge E
      #1;
      check("lat E+0 rsp_valid", 32'(rsp_valid), 32'h0);
      idle_cycle();
      check("lat E+1 rsp_valid", 32'(rsp_valid), 32'h0);
      idle_cycle();
      check("lat E+2 rsp_valid", 32'(rsp_valid), 32'h8);
      check("lat E+2 rsp_data3", 32'(rsp_data[31:24]), 32'h34);
      idle_cycle();
      check("lat E+3 rsp_valid", 32'(rsp_valid), 32'h0);
      check("lat E+3 rsp_data3 hold", 32'(rsp_data[31:24]), 32'h34);
      $display("latency read r3 addr13: data=%h", rsp_data[31:24]);

      // ---------------- bank conflict: r0 rd 5, r2 rd 2 ----------------
      @(negedge clk);
      req_valid = 4'b0101;
      req_we    = 4'b0000;
      req_addr  = {5'd0, 5'd2, 5'd0, 5'd5};
      #1;
      check("conflict N ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      check("conflict N+1 ready", 32'(req_ready), 32'h4);
      @(posedge clk);
      #1;
      check("conflict N+1 rsp_valid", 32'(rsp_valid), 32'h0);
      idle_cycle();
      check("conflict N+2 rsp_valid", 32'(rsp_valid), 32'h1);
      check("conflict rsp_data0", 32'(rsp_data[7:0]), 32'h12);
      idle_cycle();
      check("conflict N+3 rsp_valid", 32'(rsp_valid), 32'h4);
      check("conflict rsp_data2", 32'(rsp_data[23:16]), 32'h00);
      $display("bank conflict: rsp0=%h rsp2=%h", rsp_data[7:0], rsp_data[23:16]);

      // ---------------- mid-flight reset ----------------
      @(negedge clk);
      req_valid = 4'b0100;
      req_addr  = {5'd0, 5'd2, 5'd0, 5'd0};
      #1;
      check("midrst ready", 32'(req_ready), 32'h4);
      @(posedge clk);   // handshake edge H
      @(negedge clk);
      req_valid = 4'b0000;
      rst       = 1'b1;
      @(posedge clk);   // H+1, reset sampled
      #1;
      check("midrst H+1 rsp_valid", 32'(rsp_valid), 32'h0);
      check("midrst H+1 rsp_data", rsp_data, 32'h0);
      check("midrst H+1 en_a", 32'(mem_en_a), 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'b0010;
      req_addr  = {5'd0, 5'd0, 5'd13, 5'd0};
      #1;
      check("midrst hold ready", 32'(req_ready), 32'h0);
      @(posedge clk);   // H+2: the discarded read would have answered here
      #1;
      check("midrst H+2 rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      check("midrst regrant ready", 32'(req_ready), 32'h2);
      @(posedge clk);
      #1;
      check("midrst regrant cmd", 32'({mem_en_a, mem_we_a, mem_addr_a}), 32'({1'b1, 1'b0, 5'd13}));
      check("midrst H+3 rsp_valid", 32'(rsp_valid), 32'h0);
      idle_cycle();
      check("midrst G+1 rsp_valid", 32'(rsp_valid), 32'h0);
      idle_cycle();
      check("midrst G+2 rsp_valid", 32'(rsp_valid), 32'h2);
      check("midrst rsp_data1", 32'(rsp_data[15:8]), 32'h34);
      $display("mid-flight reset: regranted r1 rd 13, data=%h", rsp_data[15:8]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
